d_mem_responder: RTL and testbench

Data-memory responder for the 16-bit CPU: the slave end of the `d_mem_cs` / `d_mem_rw_` interface driven by the controller. It accepts one load or store per request, inserts a configurable number of wait states, performs the access on a single-port word array, and returns read data with a one-cycle `ready` pulse. It sits between the ALU result and register-file write data on one side, and the `data_out` mux feeding the register file on the other.

---
 rtl/cpu16_pkg.sv | 16 +
 rtl/dmem_array.sv | 20 ++
 rtl/d_mem_responder.sv | 133 +++++++++++++
 tb/tb_d_mem_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit CPU datapath and its data-memory responder.
package cpu16_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  // rw_ encoding shared with the controller
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with a registered read port; no reset on contents.
module dmem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wd;
    rd <= mem_q[addr];
  end

endmodule

// File: rtl/d_mem_responder.sv
// Data-memory responder: accepts one load/store, inserts WAIT_STATES wait cycles, then pulses ready.
// state | meaning:  IDLE accept on cs | WAIT count down to access | RESP ready pulse, back to IDLE
module d_mem_responder
  import cpu16_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              rw_,
  input  logic [15:0]       addr,
  input  logic [15:0]       wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              addr_err
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  dmem_state_t       state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rw_q;
  logic              oor_q;
  logic              ready_q;
  logic              busy_q;
  logic              err_q;

  logic              in_oor;
  logic              access;
  logic              acc_rw;
  logic              acc_oor;
  logic              arr_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wd;
  logic [DATA_W-1:0] arr_rd;

  assign in_oor = (addr >> ADDR_W) != 16'h0000;

  // With zero wait states the access happens on the acceptance edge, straight from the inputs.
  always_comb begin
    access   = 1'b0;
    acc_addr = addr_q;
    acc_wd   = wdata_q;
    acc_rw   = rw_q;
    acc_oor  = oor_q;
    if (state_q == IDLE) begin
      access   = cs && (WS == 4'd0);
      acc_addr = addr[ADDR_W-1:0];
      acc_wd   = wdata;
      acc_rw   = rw_;
      acc_oor  = in_oor;
    end else if (state_q == WAIT) begin
      access = (cnt_q == 4'd1);
    end
  end

  assign arr_we = access && (acc_rw == RW_WRITE) && !acc_oor;

  dmem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk (clk),
    .we  (arr_we),
    .addr(acc_addr),
    .wd  (acc_wd),
    .rd  (arr_rd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rw_q    <= RW_READ;
      oor_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cs) begin
            addr_q  <= addr[ADDR_W-1:0];
            wdata_q <= wdata;
            rw_q    <= rw_;
            oor_q   <= in_oor;
            busy_q  <= 1'b1;
            if (WS == 4'd0) begin
              state_q <= RESP;
              ready_q <= 1'b1;
              err_q   <= in_oor;
            end else begin
              cnt_q   <= WS;
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= RESP;
            ready_q <= 1'b1;
            err_q   <= oor_q;
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (rw_q == RW_READ) rdata_q <= rdata;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Load data shows straight from the array's read register in RESP and is held afterwards.
  assign rdata    = (ready_q && rw_q == RW_READ) ? (oor_q ? '0 : arr_rd) : rdata_q;
  assign ready    = ready_q;
  assign busy     = busy_q;
  assign addr_err = err_q;

endmodule

// File: tb/tb_d_mem_responder.sv
// Bench for d_mem_responder: three instances (0, 1 and 3 wait states) against a request-level model.
module tb_d_mem_responder;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs    [N];
  logic        rw_   [N];
  logic [15:0] addr  [N];
  logic [15:0] wdata [N];
  logic [15:0] rdata [N];
  logic        ready [N];
  logic        busy  [N];
  logic        addr_err [N];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  d_mem_responder #(.ADDR_W(8), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .cs(cs[0]), .rw_(rw_[0]), .addr(addr[0]), .wdata(wdata[0]),
    .rdata(rdata[0]), .ready(ready[0]), .busy(busy[0]), .addr_err(addr_err[0]));
  d_mem_responder #(.ADDR_W(8), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst), .cs(cs[1]), .rw_(rw_[1]), .addr(addr[1]), .wdata(wdata[1]),
    .rdata(rdata[1]), .ready(ready[1]), .busy(busy[1]), .addr_err(addr_err[1]));
  d_mem_responder #(.ADDR_W(8), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .cs(cs[2]), .rw_(rw_[2]), .addr(addr[2]), .wdata(wdata[2]),
    .rdata(rdata[2]), .ready(ready[2]), .busy(busy[2]), .addr_err(addr_err[2]));

  function automatic int ws(int i);
    return (i == 0) ? 0 : (i == 1) ? 1 : 3;
  endfunction

  function automatic bit oor(logic [15:0] a);
    return a[15:8] != 8'h00;
  endfunction

  task automatic chk(string nm, int i, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d got=%0h expected=%0h t=%0t", nm, i, got, exp, $time);
    end
  endtask

  // Request-level model: a request accepted at the end of cycle 0 completes in cycle ws+1.
  bit          act [N];
  int          k   [N];
  bit          m_rw [N];
  logic [15:0] m_a  [N];
  logic [15:0] m_wd [N];
  bit          e_busy [N];
  bit          e_ready [N];
  bit          e_err [N];
  logic [15:0] e_rdata [N];
  bit          e_rd_known [N];
  logic [15:0] mem   [N][256];
  bit          known [N][256];

  initial begin
    for (int i = 0; i < N; i++) begin
      act[i] = 0; k[i] = 0; e_busy[i] = 0; e_ready[i] = 0; e_err[i] = 0;
      e_rdata[i] = 16'h0; e_rd_known[i] = 1;
      for (int j = 0; j < 256; j++) known[i][j] = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        act[i] = 0; k[i] = 0; e_busy[i] = 0; e_ready[i] = 0; e_err[i] = 0;
        e_rdata[i] = 16'h0; e_rd_known[i] = 1;
      end
    end
    for (int i = 0; i < N; i++) begin
      chk("busy", i, busy[i], e_busy[i]);
      chk("ready", i, ready[i], e_ready[i]);
      chk("addr_err", i, addr_err[i], e_err[i]);
      if (e_rd_known[i]) chk("rdata", i, rdata[i], e_rdata[i]);
    end
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        if (!act[i]) begin
          if (cs[i] === 1'b1) begin
            act[i] = 1; k[i] = 1;
            m_rw[i] = rw_[i]; m_a[i] = addr[i]; m_wd[i] = wdata[i];
          end
        end else if (k[i] == ws(i) + 1) begin
          act[i] = 0; k[i] = 0;
        end else begin
          k[i]++;
        end
        e_busy[i]  = act[i];
        e_ready[i] = act[i] && (k[i] == ws(i) + 1);
        e_err[i]   = e_ready[i] && oor(m_a[i]);
        if (e_ready[i]) begin
          if (m_rw[i]) begin
            if (oor(m_a[i])) begin
              e_rdata[i] = 16'h0; e_rd_known[i] = 1;
            end else begin
              e_rdata[i] = mem[i][m_a[i][7:0]];
              e_rd_known[i] = known[i][m_a[i][7:0]];
            end
          end else if (!oor(m_a[i])) begin
            mem[i][m_a[i][7:0]] = m_wd[i];
            known[i][m_a[i][7:0]] = 1;
          end
        end
      end
    end
  end

  task automatic req(int i, bit rw, logic [15:0] a, logic [15:0] d, bit noise,
                     output int lat, output int nbusy, output logic [15:0] rd, output logic er);
    @(posedge clk); #1;
    cs[i] = 1'b1; rw_[i] = rw; addr[i] = a; wdata[i] = d;
    @(posedge clk); #1;
    lat = 1; nbusy = 0;
    for (;;) begin
      if (busy[i]) nbusy++;
      if (ready[i]) break;
      if (lat >= 40) begin
        chk("ready_timeout", i, lat, ws(i) + 1);
        break;
      end
      cs[i] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        addr[i] = 16'($urandom); wdata[i] = 16'($urandom); rw_[i] = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      lat++;
    end
    rd = rdata[i]; er = addr_err[i];
    cs[i] = 1'b0;
  endtask

  task automatic rand_run(int i);
    int lat, nb;
    logic [15:0] rd, a;
    logic er;
    for (int j = 0; j < 16; j++)
      req(i, 1'b0, 16'(j), 16'($urandom), 1'b0, lat, nb, rd, er);
    for (int j = 0; j < 40; j++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      a = ($urandom_range(0, 9) == 0) ? (16'h0100 | 16'($urandom)) : 16'($urandom_range(0, 15));
      req(i, 1'($urandom_range(0, 1)), a, 16'($urandom), 1'b1, lat, nb, rd, er);
      chk("rand_latency", i, lat, ws(i) + 1);
    end
  endtask

  initial begin
    int lat, nb;
    logic [15:0] rd;
    logic er;
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      cs[i] = 1'b0; rw_[i] = 1'b1; addr[i] = 16'h0; wdata[i] = 16'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdata", 1, rdata[1], 16'h0000);
    chk("reset_busy", 2, busy[2], 1'b0);
    rst = 1'b1;

    // one wait state: write then read back
    req(1, 1'b0, 16'h0012, 16'hBEEF, 1'b0, lat, nb, rd, er);
    chk("ws1_wr_latency", 1, lat, 2);
    chk("ws1_wr_busy_cycles", 1, nb, 2);
    req(1, 1'b1, 16'h0012, 16'h0000, 1'b0, lat, nb, rd, er);
    chk("ws1_rd_latency", 1, lat, 2);
    chk("ws1_rd_data", 1, rd, 16'hBEEF);
    req(1, 1'b0, 16'h0013, 16'h0000, 1'b0, lat, nb, rd, er);
    chk("rdata_hold_on_write", 1, rd, 16'hBEEF);

    // zero wait states: back-to-back reads with cs held high
    req(0, 1'b0, 16'h0001, 16'h1111, 1'b0, lat, nb, rd, er);
    chk("ws0_wr_latency", 0, lat, 1);
    req(0, 1'b0, 16'h0002, 16'h2222, 1'b0, lat, nb, rd, er);
    @(posedge clk); #1;
    cs[0] = 1'b1; rw_[0] = 1'b1; addr[0] = 16'h0001;
    @(posedge clk); #1;
    chk("b2b_ready1", 0, ready[0], 1'b1);
    chk("b2b_data1", 0, rdata[0], 16'h1111);
    addr[0] = 16'h0002;
    @(posedge clk); #1;
    chk("b2b_gap", 0, ready[0], 1'b0);
    @(posedge clk); #1;
    chk("b2b_ready2", 0, ready[0], 1'b1);
    chk("b2b_data2", 0, rdata[0], 16'h2222);
    cs[0] = 1'b0;
    @(posedge clk); #1;

    // out-of-range accesses
    req(1, 1'b0, 16'h0000, 16'hAAAA, 1'b0, lat, nb, rd, er);
    req(1, 1'b0, 16'h0100, 16'h5555, 1'b0, lat, nb, rd, er);
    chk("oor_wr_err", 1, er, 1'b1);
    req(1, 1'b1, 16'h0000, 16'h0000, 1'b0, lat, nb, rd, er);
    chk("oor_wr_suppressed", 1, rd, 16'hAAAA);
    chk("inrange_err", 1, er, 1'b0);
    req(1, 1'b1, 16'h0100, 16'h0000, 1'b0, lat, nb, rd, er);
    chk("oor_rd_data", 1, rd, 16'h0000);
    chk("oor_rd_err", 1, er, 1'b1);

    // three wait states: inputs and cs wiggle during WAIT
    @(posedge clk); #1;
    cs[2] = 1'b1; rw_[2] = 1'b0; addr[2] = 16'h0040; wdata[2] = 16'h1234;
    @(posedge clk); #1;
    cs[2] = 1'b0; rw_[2] = 1'b1; addr[2] = 16'h0041; wdata[2] = 16'hFFFF;
    chk("ws3_busy_c1", 2, busy[2], 1'b1);
    @(posedge clk); #1;
    cs[2] = 1'b1;
    @(posedge clk); #1;
    cs[2] = 1'b0;
    @(posedge clk); #1;
    chk("ws3_ready_c4", 2, ready[2], 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("ws3_no_extra_ready", 2, ready[2], 1'b0);
    end
    req(2, 1'b1, 16'h0040, 16'h0000, 1'b0, lat, nb, rd, er);
    chk("ws3_latched_write", 2, rd, 16'h1234);
    chk("ws3_latency", 2, lat, 4);

    // reset in the middle of a pending write
    req(2, 1'b0, 16'h0020, 16'h7777, 1'b0, lat, nb, rd, er);
    req(2, 1'b1, 16'h0020, 16'h0000, 1'b0, lat, nb, rd, er);
    chk("pre_reset_rd", 2, rd, 16'h7777);
    @(posedge clk); #1;
    cs[2] = 1'b1; rw_[2] = 1'b0; addr[2] = 16'h0020; wdata[2] = 16'h9999;
    @(posedge clk); #1;
    cs[2] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_busy", 2, busy[2], 1'b0);
    chk("midrst_ready", 2, ready[2], 1'b0);
    chk("midrst_rdata", 2, rdata[2], 16'h0000);
    chk("midrst_err", 2, addr_err[2], 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    req(2, 1'b1, 16'h0020, 16'h0000, 1'b0, lat, nb, rd, er);
    chk("dropped_write", 2, rd, 16'h7777);

    // randomized traffic on all three instances at once
    fork
      rand_run(0);
      rand_run(1);
      rand_run(2);
    join
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached t=%0t", $time);
    $fatal(1, "global timeout");
  end

endmodule
